mem_port_arbiter: RTL and testbench

Shares a single-ported unified memory between the pipelined CPU's instruction-fetch port and data port. It arbitrates between the two requesters, sequences each access over a fixed-latency memory, and returns read data to the requester with a one-cycle completion pulse. It sits between the CPU's `i_*`/`d_*` memory interfaces and the memory model. Data accesses have priority over fetches, and a streak limit prevents fetch starvation.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU fetch/data ports and the shared memory port around mem_port_arbiter.
// The slave modport is the arbiter; the master modport is the CPU plus memory model side.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_done;
    logic                 i_stall;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_done;
    logic                 d_stall;

    logic                 m_read;
    logic                 m_write;
    logic [WORD_SIZE-1:0] m_addr;
    logic [WORD_SIZE-1:0] m_wdata;
    logic [WORD_SIZE-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               m_read, m_write, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
               m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one fixed-latency memory port.
// Data wins by default; a saturating data-grant streak lets a waiting fetch in.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [SW-1:0] d_streak;
    logic          grant_d, grant_i, last;

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_req && !(bus.i_req && d_streak == SW'(MAX_D_STREAK))) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY_D;
                end else if (bus.i_req) begin
                    grant_i  = 1'b1;
                    state_nx = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (cnt == CW'(1)) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            d_streak    <= '0;
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
            bus.i_done  <= 1'b0;
            bus.d_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;

            if (grant_d) begin
                cnt         <= CW'(MEM_LATENCY);
                bus.m_addr  <= bus.d_addr;
                bus.m_wdata <= bus.d_wdata;
                bus.m_read  <= ~bus.d_we;
                bus.m_write <= bus.d_we;
                if (d_streak != SW'(MAX_D_STREAK))
                    d_streak <= d_streak + 1'b1;
            end else if (grant_i) begin
                cnt         <= CW'(MEM_LATENCY);
                bus.m_addr  <= bus.i_addr;
                bus.m_read  <= 1'b1;
                bus.m_write <= 1'b0;
                d_streak    <= '0;
            end else if (state == IDLE && !bus.i_req) begin
                d_streak <= '0;
            end

            // Counter leaves BUSY at 1, so it never wraps below zero.
            if (state != IDLE) begin
                cnt <= cnt - 1'b1;
                if (last) begin
                    bus.m_read  <= 1'b0;
                    bus.m_write <= 1'b0;
                    bus.m_addr  <= '0;
                    if (state == BUSY_D) begin
                        bus.d_done <= 1'b1;
                        if (!bus.m_write)
                            bus.d_rdata <= bus.m_rdata;
                    end else begin
                        bus.i_done  <= 1'b1;
                        bus.i_rdata <= bus.m_rdata;
                    end
                end
            end
        end
    end

    assign bus.i_stall = bus.i_req & ~bus.i_done;
    assign bus.d_stall = bus.d_req & ~bus.d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a timeline model of grants checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_port_arbiter;
    localparam int W    = 16;
    localparam int L    = 2;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } req_t;

    req_t iq[$];
    req_t dq[$];

    int errs = 0;
    int checks = 0;
    bit chk_en = 0;
    string seq = "";
    int rd_cycles = 0;
    int ddone_cnt = 0;

    // Memory: data is presented only in the last strobe cycle, garbage otherwise.
    logic [W-1:0] mem [256];
    int scnt = 0;
    always @(posedge clk) begin
        scnt <= bus.m_read ? scnt + 1 : 0;
        if (bus.m_write) mem[bus.m_addr[7:0]] <= bus.m_wdata;
    end
    assign bus.m_rdata = (bus.m_read && scnt == L - 1) ? mem[bus.m_addr[7:0]] : 16'hDEAD;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Model: each access is described by its grant cycle; strobes, done and
    // capture cycles follow from that by arithmetic.
    int cyc = 0;
    int g_cyc = 0;
    int streak = 0;
    bit has_acc = 0, a_d = 0, a_we = 0;
    logic [W-1:0] a_addr = '0, a_wdata = '0;
    logic [W-1:0] e_ird = '0, e_drd = '0, e_addr = '0;
    bit e_rd = 0, e_wr = 0, e_idone = 0, e_ddone = 0;

    initial forever begin
        bit strobe;
        @(posedge clk);
        if (!reset_n) begin
            has_acc = 0; streak = 0; e_ird = '0; e_drd = '0;
        end else begin
            if (has_acc && cyc == g_cyc + L && !a_we) begin
                if (a_d) e_drd = mem[a_addr[7:0]];
                else     e_ird = mem[a_addr[7:0]];
            end
            if (!has_acc || cyc > g_cyc + L) begin
                if (bus.d_req && !(bus.i_req && streak == MAXS)) begin
                    has_acc = 1; g_cyc = cyc; a_d = 1; a_we = bus.d_we;
                    a_addr = bus.d_addr; a_wdata = bus.d_wdata;
                    if (streak < MAXS) streak++;
                end else if (bus.i_req) begin
                    has_acc = 1; g_cyc = cyc; a_d = 0; a_we = 0; a_addr = bus.i_addr;
                    streak = 0;
                end else begin
                    has_acc = 0; streak = 0;
                end
            end
        end
        cyc++;
        strobe  = has_acc && cyc > g_cyc && cyc <= g_cyc + L;
        e_rd    = strobe && !a_we;
        e_wr    = strobe && a_we;
        e_addr  = strobe ? a_addr : '0;
        e_idone = has_acc && !a_d && cyc == g_cyc + L + 1;
        e_ddone = has_acc && a_d && cyc == g_cyc + L + 1;
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_read",  bus.m_read,  e_rd);
            chk("m_write", bus.m_write, e_wr);
            chk("m_addr",  bus.m_addr,  e_addr);
            if (e_wr) chk("m_wdata", bus.m_wdata, a_wdata);
            chk("i_done",  bus.i_done,  e_idone);
            chk("d_done",  bus.d_done,  e_ddone);
            chk("i_rdata", bus.i_rdata, e_ird);
            chk("d_rdata", bus.d_rdata, e_drd);
            chk("i_stall", bus.i_stall, bus.i_req & ~e_idone);
            chk("d_stall", bus.d_stall, bus.d_req & ~e_ddone);
            chk("done_excl", bus.i_done & bus.d_done, 0);
            if (bus.m_read) rd_cycles++;
            if (bus.d_done) begin ddone_cnt++; seq = {seq, "D"}; end
            if (bus.i_done) seq = {seq, "I"};
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    // Serve both queues; a port presents its next request in its done cycle.
    task automatic run(input string nm, input int maxc);
        int n = 0;
        req_t r;
        do begin
            if (bus.i_done) bus.i_req = 0;
            if (bus.d_done) begin bus.d_req = 0; bus.d_we = 0; bus.d_wdata = '0; end
            if (!bus.i_req && iq.size() > 0) begin
                r = iq.pop_front(); bus.i_req = 1; bus.i_addr = r.addr;
            end
            if (!bus.d_req && dq.size() > 0) begin
                r = dq.pop_front(); bus.d_req = 1; bus.d_we = r.we;
                bus.d_addr = r.addr; bus.d_wdata = r.wdata;
            end
            if (bus.i_req || bus.d_req) begin cycle(); n++; end
        end while ((bus.i_req || bus.d_req) && n < maxc);
        chk({nm, "_timeout"}, n < maxc, 1);
    endtask

    initial begin
        int rc;
        int dc;
        bit seen;
        for (int k = 0; k < 256; k++) mem[k] = 16'(k * 16'h0101 + 16'h0007);
        mem[8'h10] = 16'h6000;
        mem[8'h20] = 16'h1234;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        #1;
        chk("rst_m_read", bus.m_read, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        reset_n = 1;
        cycle(); cycle();

        // Plain fetch
        rc = rd_cycles;
        iq.push_back('{1'b0, 16'h0010, 16'h0000});
        run("fetch", 20);
        chk("fetch_rdata", bus.i_rdata, 16'h6000);
        chk("fetch_strobes", rd_cycles - rc, L);

        // Data write
        rc = rd_cycles;
        dq.push_back('{1'b1, 16'h00C0, 16'hBEEF});
        run("write", 20);
        cycle();
        chk("write_mem", mem[8'hC0], 16'hBEEF);
        chk("write_drdata", bus.d_rdata, 16'h0000);
        chk("write_no_read", rd_cycles - rc, 0);

        // Simultaneous requests: data first, fetch granted in the d_done cycle
        seq = "";
        dq.push_back('{1'b0, 16'h0020, 16'h0000});
        iq.push_back('{1'b0, 16'h0040, 16'h0000});
        run("both", 40);
        chk("both_drdata", bus.d_rdata, 16'h1234);
        chk("both_order", (seq == "DI") ? 1 : 0, 1);

        // Streak limit: four data grants, one fetch, then data resumes
        seq = "";
        for (int k = 0; k < 6; k++) dq.push_back('{1'b0, 16'(16'h0030 + k), 16'h0000});
        iq.push_back('{1'b0, 16'h0050, 16'h0000});
        run("streak", 200);
        chk("streak_order", (seq == "DDDDIDD") ? 1 : 0, 1);

        // Reset in the first strobe cycle of a data read
        cycle();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0020;
        cycle();
        chk("abort_strobe_on", bus.m_read, 1);
        dc = ddone_cnt;
        reset_n = 0; bus.d_req = 0;
        cycle();
        reset_n = 1;
        chk("abort_m_read", bus.m_read, 0);
        repeat (5) cycle();
        chk("abort_no_done", ddone_cnt - dc, 0);
        chk("abort_drdata", bus.d_rdata, 16'h0000);
        chk("abort_irdata", bus.i_rdata, 16'h0000);
        iq.push_back('{1'b0, 16'h0010, 16'h0000});
        run("after_rst", 20);
        chk("after_rst_rdata", bus.i_rdata, 16'h6000);

        // Fetch withdrawn while data is in flight is never serviced
        cycle();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0021;
        cycle();
        bus.i_req = 1; bus.i_addr = 16'h0060;
        cycle();
        bus.i_req = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle();
            if (bus.d_done) seen = 1;
        end
        chk("drop_done_seen", seen, 1);
        bus.d_req = 0;
        rc = rd_cycles;
        repeat (4) cycle();
        chk("drop_no_fetch", rd_cycles - rc, 0);
        chk("drop_i_stall", bus.i_stall, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
